hline_zbuff_ctrl: RTL and testbench

//  Parametrised control FSM for the z-buffered horizontal-line engine. It splits a line of dx pixels into

---
 rtl/hline_zbuff_pkg.sv | 19 +
 rtl/hline_zinterp.sv | 65 ++++++
 rtl/hline_zbuff_ctrl.sv | 148 ++++++++++++++
 tb/tb_hline_zbuff_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hline_zbuff_pkg.sv
// Shared types for the z-buffered horizontal-line engine: FSM state encodings
// and depth-function codes.
package hline_zbuff_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_RD_Z   = 3'd2,
        S_INTERP = 3'd3,
        S_WR_Z   = 3'd4,
        S_WR_FB  = 3'd5
    } state_t;

    localparam logic [1:0] ZF_LESS    = 2'd0;
    localparam logic [1:0] ZF_LEQUAL  = 2'd1;
    localparam logic [1:0] ZF_GREATER = 2'd2;
    localparam logic [1:0] ZF_ALWAYS  = 2'd3;

endpackage

// File: rtl/hline_zinterp.sv
// Per-pixel z stepper (Bresenham-corrected integer slope) with the depth test
// and the z-line write-back mux.
module hline_zinterp
    import hline_zbuff_pkg::*;
#(
    parameter int Z_W   = 32,
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_nreset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_zfunc,
    input  logic [Z_W-1:0]   i_z1,
    input  logic [Z_W-1:0]   i_slope,
    input  logic [Z_W-1:0]   i_zrd_data,
    input  logic [LEN_W-1:0] i_err,
    input  logic [LEN_W-1:0] i_rem,
    input  logic [LEN_W-1:0] i_dx,
    output logic             o_pass,
    output logic [Z_W-1:0]   o_zsel
);

    logic [Z_W-1:0]   r_zsum;
    logic [LEN_W-1:0] r_error;
    logic [LEN_W:0]   w_e;
    logic             w_carry;
    logic [Z_W-1:0]   w_adj;

    assign w_e     = {1'b0, r_error} + {1'b0, i_rem};
    assign w_carry = (w_e >= {1'b0, i_dx});
    // The extra unit step follows the sign of the slope.
    assign w_adj   = i_slope[Z_W-1] ? {Z_W{1'b1}} : Z_W'(1);

    always_comb begin
        o_pass = 1'b0;
        case (i_zfunc)
            ZF_LESS:    o_pass = (r_zsum <  i_zrd_data);
            ZF_LEQUAL:  o_pass = (r_zsum <= i_zrd_data);
            ZF_GREATER: o_pass = (r_zsum >  i_zrd_data);
            default:    o_pass = 1'b1;
        endcase
    end

    assign o_zsel = o_pass ? r_zsum : i_zrd_data;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_zsum  <= '0;
            r_error <= '0;
        end else if (i_load) begin
            r_zsum  <= i_z1;
            r_error <= i_err;
        end else if (i_step) begin
            if (w_carry) begin
                r_error <= LEN_W'(w_e - {1'b0, i_dx});
                r_zsum  <= r_zsum + i_slope + w_adj;
            end else begin
                r_error <= w_e[LEN_W-1:0];
                r_zsum  <= r_zsum + i_slope;
            end
        end
    end

endmodule

// File: rtl/hline_zbuff_ctrl.sv
// Control FSM for the z-buffered horizontal-line engine: burst splitting, bus
// requests and FIFO handshakes around the hline_zinterp pixel stepper.
module hline_zbuff_ctrl
    import hline_zbuff_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int Z_W           = 32,
    parameter int LEN_W         = 16,
    parameter int MAX_BURST     = 256,
    parameter int BYTES_PER_PIX = 4,
    parameter int CNT_W         = $clog2(MAX_BURST + 1)
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic              i_start,
    input  logic [1:0]        i_cfg_zfunc,
    input  logic              i_cfg_zwrite_en,
    input  logic [ADDR_W-1:0] i_fb_addr,
    input  logic [ADDR_W-1:0] i_zbuff_addr,
    input  logic [LEN_W-1:0]  i_dx,
    input  logic [Z_W-1:0]    i_slope,
    input  logic [Z_W-1:0]    i_z1,
    input  logic [LEN_W-1:0]  i_rem,
    input  logic [LEN_W-1:0]  i_err,
    input  logic              i_zrd_empty,
    input  logic [Z_W-1:0]    i_zrd_data,
    output logic              o_zrd_pop,
    output logic              o_zwr_push,
    output logic [Z_W-1:0]    o_zwr_data,
    output logic              o_be_push,
    output logic              o_be_data,
    output logic              o_rd_req,
    output logic              o_wr_req,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [CNT_W-1:0]  o_burst_len,
    input  logic              i_axi_done,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_curr_state
);

    state_t            r_state;
    logic [LEN_W-1:0]  r_remain;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_offset;
    logic              w_step;
    logic              w_load;
    logic              w_pass;
    logic [Z_W-1:0]    w_zsel;
    logic [CNT_W-1:0]  w_take;
    logic [ADDR_W-1:0] w_bytes;

    assign w_load  = (r_state == S_IDLE) && i_start;
    assign w_step  = (r_state == S_INTERP) && !i_zrd_empty && (r_cnt != '0);
    assign w_take  = (32'(r_remain) > MAX_BURST) ? CNT_W'(MAX_BURST) : CNT_W'(r_remain);
    assign w_bytes = ADDR_W'(o_burst_len) * ADDR_W'(BYTES_PER_PIX);

    assign o_zrd_pop    = w_step;
    assign o_zwr_push   = w_step;
    assign o_be_push    = w_step;
    assign o_zwr_data   = w_step ? w_zsel : '0;
    assign o_be_data    = w_step & w_pass;
    assign o_curr_state = r_state;

    hline_zinterp #(
        .Z_W   (Z_W),
        .LEN_W (LEN_W)
    ) u_zinterp (
        .i_clk      (i_clk),
        .i_nreset   (i_nreset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_zfunc    (i_cfg_zfunc),
        .i_z1       (i_z1),
        .i_slope    (i_slope),
        .i_zrd_data (i_zrd_data),
        .i_err      (i_err),
        .i_rem      (i_rem),
        .i_dx       (i_dx),
        .o_pass     (w_pass),
        .o_zsel     (w_zsel)
    );

    // Bus request, address and length are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state     <= S_IDLE;
            r_remain    <= '0;
            r_cnt       <= '0;
            r_offset    <= '0;
            o_rd_req    <= 1'b0;
            o_wr_req    <= 1'b0;
            o_bus_addr  <= '0;
            o_burst_len <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_remain <= i_dx;
                    r_offset <= '0;
                    o_busy   <= 1'b1;
                    r_state  <= S_SETUP;
                end
                S_SETUP: if (r_remain == '0) begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end else begin
                    o_burst_len <= w_take;
                    r_remain    <= r_remain - LEN_W'(w_take);
                    o_rd_req    <= 1'b1;
                    o_bus_addr  <= i_zbuff_addr + r_offset;
                    r_state     <= S_RD_Z;
                end
                S_RD_Z: if (i_axi_done) begin
                    o_rd_req <= 1'b0;
                    r_cnt    <= o_burst_len;
                    r_state  <= S_INTERP;
                end
                S_INTERP: if (r_cnt == '0) begin
                    o_wr_req <= 1'b1;
                    if (i_cfg_zwrite_en) begin
                        o_bus_addr <= i_zbuff_addr + r_offset;
                        r_state    <= S_WR_Z;
                    end else begin
                        o_bus_addr <= i_fb_addr + r_offset;
                        r_state    <= S_WR_FB;
                    end
                end else if (w_step) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_WR_Z: if (i_axi_done) begin
                    o_bus_addr <= i_fb_addr + r_offset;
                    r_state    <= S_WR_FB;
                end
                S_WR_FB: if (i_axi_done) begin
                    o_wr_req <= 1'b0;
                    r_offset <= r_offset + w_bytes;
                    r_state  <= S_SETUP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// Directed bench for hline_zbuff_ctrl: a negedge-driven bus/FIFO responder plus
// one task per scenario with hand-computed expectations.
module tb_hline_zbuff_ctrl;

    logic        clk = 1'b0;
    logic        nreset;
    logic        i_start;
    logic [1:0]  i_cfg_zfunc;
    logic        i_cfg_zwrite_en;
    logic [31:0] i_fb_addr, i_zbuff_addr;
    logic [15:0] i_dx, i_rem, i_err;
    logic [31:0] i_slope, i_z1;
    logic        i_zrd_empty = 1'b0;
    logic [31:0] i_zrd_data = 32'd0;
    logic        i_axi_done = 1'b0;
    logic        o_zrd_pop, o_zwr_push, o_be_push, o_be_data;
    logic [31:0] o_zwr_data, o_bus_addr;
    logic        o_rd_req, o_wr_req, o_busy, o_done;
    logic [8:0]  o_burst_len;
    logic [2:0]  o_curr_state;

    localparam logic [31:0] FB = 32'h1000_0000;
    localparam logic [31:0] ZB = 32'h2000_0000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          isRd;
        logic [31:0] addr;
        logic [8:0]  len;
    } burst_t;

    // Owned by the initial block
    logic [31:0] zSrc[$];
    int          epoch = 0;
    bit          emptyToggle = 1'b0;

    // Owned by the responder
    int          seenEpoch = 0;
    int          popIdx = 0;
    int          axiCnt = 0;
    logic [31:0] pushZ[$];
    logic        pushBe[$];
    burst_t      bursts[$];
    int          pushOnEmpty = 0;
    int          syncErr = 0;
    int          donePulses = 0;
    bit          anyReq = 1'b0;

    hline_zbuff_ctrl dut (
        .i_clk           (clk),
        .i_nreset        (nreset),
        .i_start         (i_start),
        .i_cfg_zfunc     (i_cfg_zfunc),
        .i_cfg_zwrite_en (i_cfg_zwrite_en),
        .i_fb_addr       (i_fb_addr),
        .i_zbuff_addr    (i_zbuff_addr),
        .i_dx            (i_dx),
        .i_slope         (i_slope),
        .i_z1            (i_z1),
        .i_rem           (i_rem),
        .i_err           (i_err),
        .i_zrd_empty     (i_zrd_empty),
        .i_zrd_data      (i_zrd_data),
        .o_zrd_pop       (o_zrd_pop),
        .o_zwr_push      (o_zwr_push),
        .o_zwr_data      (o_zwr_data),
        .o_be_push       (o_be_push),
        .o_be_data       (o_be_data),
        .o_rd_req        (o_rd_req),
        .o_wr_req        (o_wr_req),
        .o_bus_addr      (o_bus_addr),
        .o_burst_len     (o_burst_len),
        .i_axi_done      (i_axi_done),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_curr_state    (o_curr_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Bus and FIFO responder: each request gets axi_done after two cycles.
    always @(negedge clk) begin
        burst_t b;
        if (epoch != seenEpoch) begin
            seenEpoch   = epoch;
            popIdx      = 0;
            pushZ.delete();
            pushBe.delete();
            bursts.delete();
            pushOnEmpty = 0;
            syncErr     = 0;
            donePulses  = 0;
            anyReq      = 1'b0;
        end
        if (!nreset) begin
            i_axi_done = 1'b0;
            axiCnt     = 0;
        end else if (i_axi_done) begin
            i_axi_done = 1'b0;
            axiCnt     = 0;
        end else if (o_rd_req || o_wr_req) begin
            axiCnt++;
            if (axiCnt >= 2) begin
                i_axi_done = 1'b1;
                b.isRd = o_rd_req;
                b.addr = o_bus_addr;
                b.len  = o_burst_len;
                bursts.push_back(b);
            end
        end
        if (o_rd_req || o_wr_req) anyReq = 1'b1;
        if (o_done) donePulses++;
        if (o_zrd_pop !== o_zwr_push || o_zwr_push !== o_be_push) syncErr++;
        if (o_zwr_push) begin
            pushZ.push_back(o_zwr_data);
            pushBe.push_back(o_be_data);
            if (i_zrd_empty) pushOnEmpty++;
            popIdx++;
        end
        i_zrd_data  = (popIdx < zSrc.size()) ? zSrc[popIdx] : 32'd0;
        i_zrd_empty = emptyToggle ? ~i_zrd_empty : 1'b0;
    end

    task automatic startLine(input logic [15:0] dx, input logic [31:0] z1, input logic [31:0] slope,
                             input logic [15:0] rem, input logic [15:0] err, input logic [1:0] zf,
                             input logic zen);
        i_dx = dx; i_z1 = z1; i_slope = slope; i_rem = rem; i_err = err;
        i_cfg_zfunc = zf; i_cfg_zwrite_en = zen;
        epoch++;
        @(posedge clk);
        @(negedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        for (int c = 0; c < budget && donePulses == 0; c++) @(negedge clk);
        #1;
        checks++;
        if (donePulses == 0) begin
            $display("[TB] FAIL %s_timeout: no done pulse within %0d cycles", name, budget);
            errors++;
        end
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #1;
        checks++;
        if ({o_zrd_pop, o_zwr_push, o_zwr_data, o_be_push, o_be_data, o_rd_req, o_wr_req,
             o_bus_addr, o_burst_len, o_busy, o_done, o_curr_state} !== '0) begin
            $display("[TB] FAIL reset_outputs: state=%0d busy=%b rd=%b wr=%b expected all zero",
                     o_curr_state, o_busy, o_rd_req, o_wr_req);
            errors++;
        end
        repeat (3) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_burst_split();
        zSrc.delete();
        emptyToggle = 1'b0;
        startLine(16'd600, 32'd0, 32'd0, 16'd0, 16'd0, 2'd3, 1'b1);
        repeat (50) @(negedge clk);
        // A start pulse during an active line must be ignored.
        #1 i_start = 1'b1;
        @(negedge clk);
        #1 i_start = 1'b0;
        waitDone("split", 3000);
        checks++;
        if (bursts.size() != 9) begin
            $display("[TB] FAIL split_burst_count: got %0d expected 9", bursts.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] off;
                logic [8:0]  len;
                off = 32'(i) * 32'd1024;
                len = (i < 2) ? 9'd256 : 9'd88;
                checks++;
                if (bursts[3*i].isRd !== 1'b1 || bursts[3*i].addr !== ZB + off || bursts[3*i].len !== len) begin
                    $display("[TB] FAIL split_rdz_%0d: rd=%b addr=%h len=%0d expected rd=1 addr=%h len=%0d",
                             i, bursts[3*i].isRd, bursts[3*i].addr, bursts[3*i].len, ZB + off, len);
                    errors++;
                end
                checks++;
                if (bursts[3*i+1].isRd !== 1'b0 || bursts[3*i+1].addr !== ZB + off || bursts[3*i+1].len !== len) begin
                    $display("[TB] FAIL split_wrz_%0d: rd=%b addr=%h len=%0d expected rd=0 addr=%h len=%0d",
                             i, bursts[3*i+1].isRd, bursts[3*i+1].addr, bursts[3*i+1].len, ZB + off, len);
                    errors++;
                end
                checks++;
                if (bursts[3*i+2].isRd !== 1'b0 || bursts[3*i+2].addr !== FB + off || bursts[3*i+2].len !== len) begin
                    $display("[TB] FAIL split_wrfb_%0d: rd=%b addr=%h len=%0d expected rd=0 addr=%h len=%0d",
                             i, bursts[3*i+2].isRd, bursts[3*i+2].addr, bursts[3*i+2].len, FB + off, len);
                    errors++;
                end
            end
        end
        checks++;
        if (donePulses != 1 || pushZ.size() != 600 || o_busy !== 1'b0) begin
            $display("[TB] FAIL split_totals: done=%0d pushes=%0d busy=%b expected 1/600/0",
                     donePulses, pushZ.size(), o_busy);
            errors++;
        end
    endtask

    task automatic test_zero_len();
        zSrc.delete();
        startLine(16'd0, 32'd0, 32'd0, 16'd0, 16'd0, 2'd3, 1'b1);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1 || o_curr_state !== 3'd1) begin
            $display("[TB] FAIL zero_first_edge: done=%b busy=%b state=%0d expected 0/1/1",
                     o_done, o_busy, o_curr_state);
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_curr_state !== 3'd0) begin
            $display("[TB] FAIL zero_done: done=%b busy=%b state=%0d expected 1/0/0",
                     o_done, o_busy, o_curr_state);
            errors++;
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (anyReq !== 1'b0 || donePulses != 1) begin
            $display("[TB] FAIL zero_no_bus: anyReq=%b done=%0d expected 0/1", anyReq, donePulses);
            errors++;
        end
    endtask

    task automatic test_interp();
        logic [31:0] expZ[5];
        logic [31:0] expN[2];
        expZ = '{32'd10, 32'd12, 32'd14, 32'd16, 32'd19};
        zSrc = {32'd100, 32'd100, 32'd100, 32'd100, 32'd100};
        // Initial error of 1 makes the fourth step cross dx=5 (e=5), adding +1.
        startLine(16'd5, 32'd10, 32'd2, 16'd1, 16'd1, 2'd0, 1'b1);
        waitDone("interp", 400);
        checks++;
        if (pushZ.size() != 5) begin
            $display("[TB] FAIL interp_count: got %0d expected 5", pushZ.size());
            errors++;
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pushZ[i] !== expZ[i] || pushBe[i] !== 1'b1) begin
                    $display("[TB] FAIL interp_pix_%0d: z=%0d be=%b expected z=%0d be=1",
                             i, pushZ[i], pushBe[i], expZ[i]);
                    errors++;
                end
            end
        end
        // Negative slope: 10, then 10-3 = 7 (e=1 < dx=2, no correction).
        expN = '{32'd10, 32'd7};
        zSrc = {32'd0, 32'd0};
        startLine(16'd2, 32'd10, -32'sd3, 16'd1, 16'd0, 2'd3, 1'b1);
        waitDone("interp_neg", 400);
        checks++;
        if (pushZ.size() != 2 || pushZ[0] !== expN[0] || pushZ[1] !== expN[1]) begin
            $display("[TB] FAIL interp_neg: n=%0d z0=%0d z1=%0d expected 2 pixels 10,7",
                     pushZ.size(), pushZ.size() > 0 ? pushZ[0] : 0, pushZ.size() > 1 ? pushZ[1] : 0);
            errors++;
        end
    endtask

    task automatic test_depth_funcs();
        logic [1:0]  fn[4];
        logic [1:0]  eBe[4];
        logic [31:0] eZ0[4];
        logic [31:0] eZ1[4];
        logic [31:0] src0[4];
        logic [31:0] src1[4];
        fn   = '{2'd0, 2'd2, 2'd3, 2'd1};
        src0 = '{32'd5, 32'd5, 32'd5, 32'd10};
        src1 = '{32'd20, 32'd20, 32'd20, 32'd5};
        eBe  = '{2'b01, 2'b10, 2'b11, 2'b10};
        eZ0  = '{32'd5, 32'd10, 32'd10, 32'd10};
        eZ1  = '{32'd10, 32'd20, 32'd10, 32'd5};
        for (int k = 0; k < 4; k++) begin
            zSrc = {src0[k], src1[k]};
            startLine(16'd2, 32'd10, 32'd0, 16'd0, 16'd0, fn[k], 1'b1);
            waitDone("depth", 400);
            checks++;
            if (pushZ.size() != 2) begin
                $display("[TB] FAIL depth_count_f%0d: got %0d expected 2", fn[k], pushZ.size());
                errors++;
            end else if ({pushBe[0], pushBe[1]} !== eBe[k] || pushZ[0] !== eZ0[k] || pushZ[1] !== eZ1[k]) begin
                $display("[TB] FAIL depth_f%0d: be=%b%b z=%0d,%0d expected be=%b z=%0d,%0d",
                         fn[k], pushBe[0], pushBe[1], pushZ[0], pushZ[1], eBe[k], eZ0[k], eZ1[k]);
                errors++;
            end
        end
    endtask

    task automatic test_stall_no_zwrite();
        zSrc.delete();
        emptyToggle = 1'b1;
        startLine(16'd8, 32'd1, 32'd1, 16'd0, 16'd0, 2'd3, 1'b0);
        waitDone("stall", 600);
        emptyToggle = 1'b0;
        checks++;
        if (pushZ.size() != 8 || pushOnEmpty != 0 || syncErr != 0) begin
            $display("[TB] FAIL stall_pushes: pushes=%0d onEmpty=%0d unsynced=%0d expected 8/0/0",
                     pushZ.size(), pushOnEmpty, syncErr);
            errors++;
        end
        checks++;
        if (bursts.size() != 2) begin
            $display("[TB] FAIL stall_bursts: got %0d expected 2 (no z write-back)", bursts.size());
            errors++;
        end else if (bursts[1].isRd !== 1'b0 || bursts[1].addr !== FB || bursts[1].len !== 9'd8) begin
            $display("[TB] FAIL stall_fb_burst: rd=%b addr=%h len=%0d expected 0/%h/8",
                     bursts[1].isRd, bursts[1].addr, bursts[1].len, FB);
            errors++;
        end
    endtask

    task automatic test_reset_mid_interp();
        bit seen;
        zSrc.delete();
        seen = 1'b0;
        startLine(16'd100, 32'd0, 32'd0, 16'd0, 16'd0, 2'd3, 1'b1);
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (o_zwr_push) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("[TB] FAIL midreset_reach_interp: push never seen within 300 cycles");
            errors++;
        end
        nreset = 1'b0;
        #1;
        checks++;
        if ({o_zrd_pop, o_zwr_push, o_zwr_data, o_be_push, o_be_data, o_rd_req, o_wr_req,
             o_bus_addr, o_burst_len, o_busy, o_done, o_curr_state} !== '0) begin
            $display("[TB] FAIL midreset_outputs: state=%0d pop=%b busy=%b addr=%h expected all zero",
                     o_curr_state, o_zrd_pop, o_busy, o_bus_addr);
            errors++;
        end
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        zSrc = {32'd0, 32'd0, 32'd0};
        startLine(16'd3, 32'd7, 32'd1, 16'd0, 16'd0, 2'd3, 1'b1);
        waitDone("midreset_restart", 400);
        checks++;
        if (pushZ.size() != 3 || bursts.size() != 3 || donePulses != 1) begin
            $display("[TB] FAIL midreset_restart: pushes=%0d bursts=%0d done=%0d expected 3/3/1",
                     pushZ.size(), bursts.size(), donePulses);
            errors++;
        end else if (pushZ[0] !== 32'd7 || pushZ[1] !== 32'd8 || pushZ[2] !== 32'd9) begin
            $display("[TB] FAIL midreset_z: got %0d,%0d,%0d expected 7,8,9", pushZ[0], pushZ[1], pushZ[2]);
            errors++;
        end
    endtask

    initial begin
        i_start = 1'b0; i_cfg_zfunc = 2'd0; i_cfg_zwrite_en = 1'b1;
        i_fb_addr = FB; i_zbuff_addr = ZB;
        i_dx = '0; i_rem = '0; i_err = '0; i_slope = '0; i_z1 = '0;
        test_reset();
        test_zero_len();
        test_interp();
        test_depth_funcs();
        test_stall_no_zwrite();
        test_burst_split();
        test_reset_mid_interp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
